// File: rtl/preg_freelist_pkg.sv
// Shared rename-stage types for the physical register freelist.
// Pointer, address and depth definitions used by preg_freelist.
package preg_freelist_pkg;

    localparam int FREELIST_DEPTH = 32;

    typedef logic [5:0] preg_addr_t;
    typedef logic [4:0] creg_addr_t;
    // Bit 5 is the wrap bit, so full (32) and empty (0) are distinguishable.
    typedef logic [5:0] fl_ptr_t;

endpackage

// File: rtl/preg_freelist.sv
// Circular freelist of physical registers with speculative/commit heads for flush recovery.
// Optional FREELIST_STATS_EN adds a saturating stall_cycles counter output.
module preg_freelist
    import preg_freelist_pkg::*;
#(
    parameter int MACHINE_WIDTH = 2,
    parameter int PREG_NUM      = 64,
    parameter int CREG_NUM      = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [MACHINE_WIDTH-1:0]   alloc_req,
    output logic                       alloc_ok,
    output logic [MACHINE_WIDTH*6-1:0] alloc_preg,
    input  logic [MACHINE_WIDTH-1:0]   retire_valid,
    input  logic [MACHINE_WIDTH*6-1:0] retire_old_preg,
    input  logic                       flush,
    output logic [5:0]                 free_count
`ifdef FREELIST_STATS_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    localparam int DEPTH = PREG_NUM - CREG_NUM;

    preg_addr_t r_entry [FREELIST_DEPTH];
    fl_ptr_t    r_spec_head;
    fl_ptr_t    r_commit_head;
    fl_ptr_t    r_tail;
    fl_ptr_t    r_free_count;

    fl_ptr_t    w_alloc_n;
    fl_ptr_t    w_alloc_rank [MACHINE_WIDTH];
    fl_ptr_t    w_ret_n;
    fl_ptr_t    w_ret_rank [MACHINE_WIDTH];
    fl_ptr_t    w_ret_eff;
    logic       w_retire_en;
    logic       w_alloc_ok;
    fl_ptr_t    w_tail_nxt;
    fl_ptr_t    w_commit_nxt;
    fl_ptr_t    w_spec_nxt;

    // Slot ranks compact the active requests/retires into consecutive buffer entries.
    always_comb begin
        w_alloc_n = '0;
        w_ret_n   = '0;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            w_alloc_rank[i] = w_alloc_n;
            w_alloc_n       = w_alloc_n + fl_ptr_t'(alloc_req[i]);
            w_ret_rank[i]   = w_ret_n;
            w_ret_n         = w_ret_n + fl_ptr_t'(retire_valid[i]);
        end
    end

    always_comb begin
        alloc_preg = '0;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            alloc_preg[i*6 +: 6] = r_entry[r_spec_head[4:0] + w_alloc_rank[i][4:0]];
        end
    end

    // A retire that would exceed the buffer capacity is dropped as a whole.
    always_comb begin
        w_alloc_ok   = !reset && !flush && (w_alloc_n <= r_free_count);
        w_retire_en  = ({1'b0, r_free_count} + {1'b0, w_ret_n}) <= 7'(DEPTH);
        w_ret_eff    = w_retire_en ? w_ret_n : '0;
        w_tail_nxt   = r_tail + w_ret_eff;
        w_commit_nxt = r_commit_head + w_ret_eff;
        if (flush) begin
            w_spec_nxt = w_commit_nxt;
        end else if (w_alloc_ok) begin
            w_spec_nxt = r_spec_head + w_alloc_n;
        end else begin
            w_spec_nxt = r_spec_head;
        end
    end

    assign alloc_ok   = w_alloc_ok;
    assign free_count = r_free_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FREELIST_DEPTH; i++) begin
                r_entry[i] <= preg_addr_t'(FREELIST_DEPTH + i);
            end
            r_spec_head   <= '0;
            r_commit_head <= '0;
            r_tail        <= fl_ptr_t'(FREELIST_DEPTH);
            r_free_count  <= fl_ptr_t'(FREELIST_DEPTH);
        end else begin
            if (w_retire_en) begin
                for (int i = 0; i < MACHINE_WIDTH; i++) begin
                    if (retire_valid[i]) begin
                        r_entry[r_tail[4:0] + w_ret_rank[i][4:0]] <= retire_old_preg[i*6 +: 6];
                    end
                end
            end
            r_spec_head   <= w_spec_nxt;
            r_commit_head <= w_commit_nxt;
            r_tail        <= w_tail_nxt;
            r_free_count  <= w_tail_nxt - w_spec_nxt;
        end
    end

`ifdef FREELIST_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if ((alloc_req != '0) && !w_alloc_ok && !flush && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_preg_freelist.sv
// Directed self-checking bench for preg_freelist (stall counter checked when FREELIST_STATS_EN is defined).
module tb_preg_freelist;

    logic        clk;
    logic        reset;
    logic [1:0]  alloc_req;
    logic        alloc_ok;
    logic [11:0] alloc_preg;
    logic [1:0]  retire_valid;
    logic [11:0] retire_old_preg;
    logic        flush;
    logic [5:0]  free_count;
`ifdef FREELIST_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int nChecks = 0;
    int nFails  = 0;

    preg_freelist dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_req       (alloc_req),
        .alloc_ok        (alloc_ok),
        .alloc_preg      (alloc_preg),
        .retire_valid    (retire_valid),
        .retire_old_preg (retire_old_preg),
        .flush           (flush),
        .free_count      (free_count)
`ifdef FREELIST_STATS_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] rv,
                                 input logic [11:0] old, input logic fl);
        alloc_req       = req;
        retire_valid    = rv;
        retire_old_preg = old;
        flush           = fl;
        #2;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(2'b00, 2'b00, 12'd0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic allocPairs(input int pairs);
        for (int i = 0; i < pairs; i++) begin
            applyStimulus(2'b11, 2'b00, 12'd0, 1'b0);
            tick();
        end
        applyStimulus(2'b00, 2'b00, 12'd0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(2'b11, 2'b11, {6'd1, 6'd2}, 1'b1);
        nChecks++;
        if (alloc_ok !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_alloc_ok: got %b expected 0", alloc_ok);
        end
        tick();
        reset = 1'b0;
        applyStimulus(2'b00, 2'b00, 12'd0, 1'b0);
        nChecks++;
        if (free_count !== 6'd32) begin
            nFails++;
            $display("[TB] FAIL reset_free_count: got %0d expected 32", free_count);
        end
`ifdef FREELIST_STATS_EN
        nChecks++;
        if (stall_cycles !== 32'd0) begin
            nFails++;
            $display("[TB] FAIL reset_stall_cycles: got %0d expected 0", stall_cycles);
        end
`endif
    endtask

    task automatic test_dual_alloc();
        doReset();
        applyStimulus(2'b11, 2'b00, 12'd0, 1'b0);
        nChecks++;
        if (alloc_ok !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL dual_alloc_ok: got %b expected 1", alloc_ok);
        end
        nChecks++;
        if (alloc_preg !== {6'd33, 6'd32}) begin
            nFails++;
            $display("[TB] FAIL dual_alloc_preg: got %0d,%0d expected 33,32", alloc_preg[11:6], alloc_preg[5:0]);
        end
        tick();
        applyStimulus(2'b00, 2'b00, 12'd0, 1'b0);
        nChecks++;
        if (free_count !== 6'd30) begin
            nFails++;
            $display("[TB] FAIL dual_alloc_free: got %0d expected 30", free_count);
        end
    endtask

    task automatic test_single_slot();
        doReset();
        applyStimulus(2'b10, 2'b00, 12'd0, 1'b0);
        nChecks++;
        if (alloc_ok !== 1'b1 || alloc_preg[11:6] !== 6'd32) begin
            nFails++;
            $display("[TB] FAIL slot1_alloc: got ok=%b preg=%0d expected ok=1 preg=32", alloc_ok, alloc_preg[11:6]);
        end
        tick();
        applyStimulus(2'b01, 2'b00, 12'd0, 1'b0);
        nChecks++;
        if (free_count !== 6'd31 || alloc_preg[5:0] !== 6'd33) begin
            nFails++;
            $display("[TB] FAIL slot1_head_advance: got free=%0d preg=%0d expected free=31 preg=33", free_count, alloc_preg[5:0]);
        end
    endtask

    task automatic test_shortfall();
        doReset();
        allocPairs(15);
        applyStimulus(2'b01, 2'b00, 12'd0, 1'b0);
        tick();
        applyStimulus(2'b11, 2'b00, 12'd0, 1'b0);
        nChecks++;
        if (free_count !== 6'd1 || alloc_ok !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL shortfall_reject: got free=%0d ok=%b expected free=1 ok=0", free_count, alloc_ok);
        end
        tick();
        applyStimulus(2'b01, 2'b00, 12'd0, 1'b0);
        nChecks++;
        if (free_count !== 6'd1 || alloc_ok !== 1'b1 || alloc_preg[5:0] !== 6'd63) begin
            nFails++;
            $display("[TB] FAIL shortfall_single: got free=%0d ok=%b preg=%0d expected free=1 ok=1 preg=63", free_count, alloc_ok, alloc_preg[5:0]);
        end
        tick();
        applyStimulus(2'b00, 2'b00, 12'd0, 1'b0);
        nChecks++;
        if (free_count !== 6'd0) begin
            nFails++;
            $display("[TB] FAIL shortfall_empty: got %0d expected 0", free_count);
        end
    endtask

    task automatic test_retire_same_cycle();
        doReset();
        allocPairs(16);
        applyStimulus(2'b01, 2'b11, {6'd5, 6'd7}, 1'b0);
        nChecks++;
        if (alloc_ok !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL retire_same_cycle_ok: got %b expected 0", alloc_ok);
        end
        tick();
        applyStimulus(2'b11, 2'b00, 12'd0, 1'b0);
        nChecks++;
        if (free_count !== 6'd2 || alloc_ok !== 1'b1 || alloc_preg !== {6'd5, 6'd7}) begin
            nFails++;
            $display("[TB] FAIL retire_reuse: got free=%0d ok=%b preg=%0d,%0d expected free=2 ok=1 preg=5,7",
                     free_count, alloc_ok, alloc_preg[11:6], alloc_preg[5:0]);
        end
        tick();
        applyStimulus(2'b00, 2'b00, 12'd0, 1'b0);
        nChecks++;
        if (free_count !== 6'd0) begin
            nFails++;
            $display("[TB] FAIL retire_reuse_drain: got %0d expected 0", free_count);
        end
    endtask

    task automatic test_retire_overflow();
        doReset();
        applyStimulus(2'b00, 2'b01, {6'd0, 6'd9}, 1'b0);
        tick();
        applyStimulus(2'b01, 2'b00, 12'd0, 1'b0);
        nChecks++;
        if (free_count !== 6'd32 || alloc_preg[5:0] !== 6'd32) begin
            nFails++;
            $display("[TB] FAIL overflow_ignored: got free=%0d preg=%0d expected free=32 preg=32", free_count, alloc_preg[5:0]);
        end
        tick();
        applyStimulus(2'b00, 2'b00, 12'd0, 1'b0);
    endtask

    task automatic test_flush();
        doReset();
        allocPairs(3);
        applyStimulus(2'b11, 2'b01, {6'd0, 6'd10}, 1'b1);
        nChecks++;
        if (free_count !== 6'd26 || alloc_ok !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL flush_suppress: got free=%0d ok=%b expected free=26 ok=0", free_count, alloc_ok);
        end
        tick();
        applyStimulus(2'b01, 2'b00, 12'd0, 1'b0);
        nChecks++;
        if (free_count !== 6'd32 || alloc_preg[5:0] !== 6'd33) begin
            nFails++;
            $display("[TB] FAIL flush_recover: got free=%0d preg=%0d expected free=32 preg=33", free_count, alloc_preg[5:0]);
        end
        tick();
        applyStimulus(2'b00, 2'b00, 12'd0, 1'b1);
        tick();
        applyStimulus(2'b01, 2'b00, 12'd0, 1'b0);
        nChecks++;
        if (free_count !== 6'd32 || alloc_preg[5:0] !== 6'd33) begin
            nFails++;
            $display("[TB] FAIL flush_commit_head: got free=%0d preg=%0d expected free=32 preg=33", free_count, alloc_preg[5:0]);
        end
        applyStimulus(2'b00, 2'b00, 12'd0, 1'b0);
    endtask

`ifdef FREELIST_STATS_EN
    task automatic test_stats();
        doReset();
        allocPairs(16);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b01, 2'b00, 12'd0, 1'b0);
            tick();
        end
        applyStimulus(2'b01, 2'b00, 12'd0, 1'b1);
        tick();
        applyStimulus(2'b00, 2'b00, 12'd0, 1'b0);
        nChecks++;
        if (stall_cycles !== 32'd3) begin
            nFails++;
            $display("[TB] FAIL stats_stall_cycles: got %0d expected 3", stall_cycles);
        end
    endtask
`endif

    initial begin
        reset           = 1'b1;
        alloc_req       = '0;
        retire_valid    = '0;
        retire_old_preg = '0;
        flush           = 1'b0;
        tick();
        test_reset();
        test_dual_alloc();
        test_single_slot();
        test_shortfall();
        test_retire_same_cycle();
        test_retire_overflow();
        test_flush();
`ifdef FREELIST_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
